// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch from program RAM into a small FIFO feeding decode.
// Optional HALT detection is compiled in with `define PREFETCH_HALT_EN.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    output logic                     o_mem_req,
    output logic [ADDR_W-1:0]        o_mem_addr,
    input  logic                     i_mem_gnt,
    input  logic [DATA_W-1:0]        i_mem_rdata,
    output logic                     o_instr_valid,
    output logic [DATA_W-1:0]        o_instr_data,
    output logic [ADDR_W-1:0]        o_instr_pc,
    input  logic                     i_instr_ready,
    input  logic                     i_redirect,
    input  logic [ADDR_W-1:0]        i_redirect_pc,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

`ifdef PREFETCH_HALT_EN
    typedef enum logic [1:0] {StBoot, StFetch, StHalted} state_e;
`else
    typedef enum logic [1:0] {StBoot, StFetch} state_e;
`endif

    state_e             r_state;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [ADDR_W-1:0]  r_pc   [DEPTH];

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_halt;

    always_comb begin
        w_full        = (r_count == CNT_W'(DEPTH));
        // No full bypass: a pop in the same cycle does not open a slot for a push.
        o_mem_req     = (r_state == StFetch) && !w_full;
        o_mem_addr    = r_fetch_pc;
        o_instr_valid = (r_count != '0);
        o_instr_data  = o_instr_valid ? r_data[r_head] : '0;
        o_instr_pc    = o_instr_valid ? r_pc[r_head]   : '0;
        o_count       = r_count;
        w_push        = o_mem_req && i_mem_gnt;
        w_pop         = o_instr_valid && i_instr_ready;
`ifdef PREFETCH_HALT_EN
        w_halt        = w_push && (i_mem_rdata == '1);
`else
        w_halt        = 1'b0;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StBoot;
            r_fetch_pc <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (i_redirect) begin
            // Redirect wins over everything, including a same-cycle push or pop.
            r_state    <= StFetch;
            r_fetch_pc <= i_redirect_pc;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                StBoot:  r_state <= StFetch;
                StFetch: begin
                    if (w_halt) begin
`ifdef PREFETCH_HALT_EN
                        r_state <= StHalted;
`endif
                    end
                end
`ifdef PREFETCH_HALT_EN
                StHalted: r_state <= StHalted;
`endif
                default: r_state <= StBoot;
            endcase

            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 1'b1;
                r_tail     <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_redirect) begin
            r_data[r_tail] <= i_mem_rdata;
            r_pc[r_tail]   <= r_fetch_pc;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: queue-based reference model plus directed scenarios.
module tb_instr_prefetch_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_gnt;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [2:0]  count;

    logic [31:0] ram [16];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    ent_t        mq[$];
    logic [7:0]  m_pc = 8'h00;
    int          m_state = 0;   // 0 boot, 1 fetch, 2 halted

    logic [31:0] dq[$];
    logic [31:0] dd[$];

    assign mem_rdata = ram[mem_addr[3:0]];

    instr_prefetch_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (8),
        .DATA_W (32)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .i_mem_gnt     (mem_gnt),
        .i_mem_rdata   (mem_rdata),
        .o_instr_valid (instr_valid),
        .o_instr_data  (instr_data),
        .o_instr_pc    (instr_pc),
        .i_instr_ready (instr_ready),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dq_at(int k);
        return (k < dq.size()) ? dq[k] : 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] dd_at(int k);
        return (k < dd.size()) ? dd[k] : 32'hBAD0_BAD0;
    endfunction

    // Compare DUT to model mid-cycle, then advance the model by the coming edge.
    always @(negedge clk) begin
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_data;
        logic [7:0]  e_ipc;
        logic [31:0] w;
        if (!rst_n) begin
            mq.delete();
            m_pc    = 8'h00;
            m_state = 0;
        end
        e_req   = (m_state == 1) && (mq.size() < DEPTH);
        e_valid = (mq.size() != 0);
        e_data  = e_valid ? mq[0].data : 32'h0;
        e_ipc   = e_valid ? mq[0].pc   : 8'h0;
        chk("mem_req",     64'(mem_req),     64'(e_req));
        chk("mem_addr",    64'(mem_addr),    64'(m_pc));
        chk("instr_valid", 64'(instr_valid), 64'(e_valid));
        chk("instr_data",  64'(instr_data),  64'(e_data));
        chk("instr_pc",    64'(instr_pc),    64'(e_ipc));
        chk("count",       64'(count),       64'(mq.size()));
        if (rst_n) begin
            if (instr_valid && instr_ready) begin
                dq.push_back(32'(instr_pc));
                dd.push_back(instr_data);
            end
            if (redirect) begin
                mq.delete();
                m_pc    = redirect_pc;
                m_state = 1;
            end else begin
                if (e_valid && instr_ready) void'(mq.pop_front());
                if (e_req && mem_gnt) begin
                    w = ram[m_pc[3:0]];
                    mq.push_back('{pc: m_pc, data: w});
`ifdef PREFETCH_HALT_EN
                    if (w == 32'hFFFF_FFFF) m_state = 2;
`endif
                    m_pc = m_pc + 8'd1;
                end
                if (m_state == 0) m_state = 1;
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'hA000_0000 | i;
        rst_n = 1'b0; mem_gnt = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        step; step;

        // Reset values
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst addr",    64'(mem_addr), 64'd0);
        chk("rst valid",   64'(instr_valid), 64'd0);
        chk("rst data",    64'(instr_data), 64'd0);
        chk("rst count",   64'(count), 64'd0);

        // Test 1: fill with ready=0
        rst_n = 1'b1;
        chk("boot mem_req", 64'(mem_req), 64'd0);
        step;
        chk("fetch mem_req", 64'(mem_req), 64'd1);
        repeat (4) step;
        chk("t1 count",   64'(count), 64'd4);
        chk("t1 mem_req", 64'(mem_req), 64'd0);
        chk("t1 pc",      64'(instr_pc), 64'd0);
        chk("t1 data",    64'(instr_data), 64'hA000_0000);

        // Test 2: continuous grant and ready from reset
        rst_n = 1'b0; instr_ready = 1'b1;
        step; step;
        rst_n = 1'b1;
        dq.delete(); dd.delete();
        repeat (8) step;
        chk("t2 ndeliv", 64'(dq.size()), 64'd6);
        for (int k = 0; k < 6; k++) chk("t2 seq", 64'(dq_at(k)), 64'(k));
        chk("t2 count", 64'(count), 64'd1);
        chk("t2 pc",    64'(instr_pc), 64'd6);

        // Test 3: toggling grant
        dq.delete(); dd.delete();
        for (int i = 0; i < 10; i++) begin
            mem_gnt = (i % 2 == 1);
            step;
        end
        mem_gnt = 1'b1;
        chk("t3 ndeliv", 64'(dq.size()), 64'd5);
        for (int k = 0; k < 5; k++) chk("t3 seq", 64'(dq_at(k)), 64'(6 + k));

        // Test 4: redirect with push and pop in the same cycle
        instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h05;
        step;
        redirect = 1'b0;
        repeat (3) step;
        chk("t4 fill count", 64'(count), 64'd3);
        chk("t4 head pc",    64'(instr_pc), 64'h05);
        chk("t4 mem_req",    64'(mem_req), 64'd1);
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
        step;
        redirect = 1'b0; instr_ready = 1'b0;
        chk("t4 flush count", 64'(count), 64'd0);
        chk("t4 flush valid", 64'(instr_valid), 64'd0);
        step;
        chk("t4 new valid", 64'(instr_valid), 64'd1);
        chk("t4 new pc",    64'(instr_pc), 64'h40);
        chk("t4 new data",  64'(instr_data), 64'hA000_0000);

        // Test 5: PC wrap
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'hFE;
        step;
        redirect = 1'b0;
        dq.delete(); dd.delete();
        repeat (5) step;
        chk("t5 pc0", 64'(dq_at(0)), 64'hFE);
        chk("t5 pc1", 64'(dq_at(1)), 64'hFF);
        chk("t5 pc2", 64'(dq_at(2)), 64'h00);
        chk("t5 pc3", 64'(dq_at(3)), 64'h01);
        chk("t5 d0",  64'(dd_at(0)), 64'hA000_000E);

        // Test 6: HALT word at address 2
        ram[2] = 32'hFFFF_FFFF;
        redirect = 1'b1; redirect_pc = 8'h00;
        step;
        redirect = 1'b0;
        dq.delete(); dd.delete();
        repeat (12) step;
`ifdef PREFETCH_HALT_EN
        chk("t6 ndeliv",  64'(dq.size()), 64'd3);
        for (int k = 0; k < 3; k++) chk("t6 seq", 64'(dq_at(k)), 64'(k));
        chk("t6 mem_req", 64'(mem_req), 64'd0);
        chk("t6 count",   64'(count), 64'd0);
        chk("t6 addr",    64'(mem_addr), 64'd3);
        ram[2] = 32'hA000_0002;
        redirect = 1'b1; redirect_pc = 8'h00;
        step;
        redirect = 1'b0;
        chk("t6 restart", 64'(mem_req), 64'd1);
`else
        chk("t6 pc2",   64'(dq_at(2)), 64'd2);
        chk("t6 data2", 64'(dd_at(2)), 64'hFFFF_FFFF);
        chk("t6 pc3",   64'(dq_at(3)), 64'd3);
        ram[2] = 32'hA000_0002;
`endif
        repeat (3) step;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
